bit_bbox_detector: RTL and testbench
====================================

// Module: bit_bbox_detector
// PURPOSE
// - Consumes the binary video stream from the erosion stage (vsync/href/clken/Bit) and measures,
//   per frame, the bounding box and pixel count of all object pixels (Bit=1).
// - Publishes the results at end of frame for the fruit classifier.
// - Passes the video on with a rectangle-border flag drawn from the previous frame's box,
//   for the display overlay.
// PARAMETERS
// - IMG_HDISP   11'd1024  active pixels per line
// - IMG_VDISP   11'd768   active lines per frame
// - MIN_PIXELS  20'd64    minimum object-pixel count for box_valid=1 (noise reject)
// PORTS
// - clk              in   1   pixel clock
// - rst_n            in   1   asynchronous, active-low reset
// - per_frame_vsync  in   1   frame active (high for the whole frame)
// - per_frame_href   in   1   line active
// - per_frame_clken  in   1   pixel strobe
// - per_img_Bit      in   1   1 = object pixel
// - post_frame_vsync out  1   vsync delayed 1 clk
// - post_frame_href  out  1   href delayed 1 clk
// - post_frame_clken out  1   clken delayed 1 clk
// - post_img_Bit     out  1   Bit delayed 1 clk, forced 0 when post_frame_href=0
// - post_box_flag    out  1   1 = current pixel lies on the border of the last valid box
// - box_x_min/x_max  out  11  column range of the last completed frame
// - box_y_min/y_max  out  11  row range of the last completed frame
// - box_pix_cnt      out  20  object-pixel count, saturating at 20'hFFFFF
// - box_valid        out  1   box_pix_cnt >= MIN_PIXELS for the last completed frame
// - box_done         out  1   one-clk pulse when all box_* outputs update
// BEHAVIOUR
// - Reset: all outputs 0; FSM to IDLE; all counters and accumulators 0.
// - Input edges: detect vsync rise/fall and href fall with 1-clk registered copies.
// - FSM IDLE: wait for vsync rise, then clear accumulators (min=all-ones, max=0, cnt=0),
//   x=0, y=0, and go to ACTIVE.
// - FSM ACTIVE:
//   - On href&clken: if Bit, min/max update with x/y and cnt+1 (saturating). Then x+1,
//     saturating at IMG_HDISP-1.
//   - On href fall: x=0, y+1, saturating at IMG_VDISP-1.
//   - On vsync fall: go to LATCH.
// - FSM LATCH (1 clk):
//   - Copy the accumulators to box_*; box_done=1; box_valid=(cnt>=MIN_PIXELS).
//   - If cnt==0, box coordinates are 0.
//   - Go to IDLE.
// - Latency: video outputs are exactly 1 clk behind the inputs. box_done fires 2 clk after
//   the vsync falling edge.
// - Simultaneous events:
//   - A pixel strobed in the same cycle as href fall or vsync fall is counted at the
//     pre-increment x/y.
//   - If vsync rises in LATCH, the rise is taken in the following IDLE cycle (edge held
//     1 clk).
// - post_box_flag:
//   - Uses the box_* registers and box_valid. It is never computed from the live
//     accumulators.
//   - Set when the pixel is inside the box, i.e. x in [x_min,x_max] and y in
//     [y_min,y_max], and it is on an edge: x==x_min | x==x_max | y==y_min | y==y_max.
//   - It is 0 when box_valid=0, and it is aligned to post_frame_clken.
// - box_* registers hold between box_done pulses and do not change mid-frame.
// - Reset mid-frame: the partial frame is discarded. The next result comes from the next
//   full frame after a vsync rise.
// - If the block leaves reset with vsync already high, there is no rise, so it waits for
//   the next frame.
// - Widths:
//   - x/y counters are 11 bits.
//   - Comparisons are unsigned.
//   - MIN_PIXELS is compared at 20 bits.
// STRUCTURE
// - Shared package/header `img_pkg`:
//   - IMG_XW=11, IMG_CNTW=20
//   - FSM encodings S_IDLE=2'd0, S_ACTIVE=2'd1, S_LATCH=2'd2
// - Sub-module `bbox_accum`: min/max/count accumulator with a clear input and a sample
//   input. It is instantiated once.
// - The top level holds the FSM, the x/y counters, the edge detectors, the video delay and
//   the border compare.
// TESTING (IMG_HDISP=16, IMG_VDISP=8, MIN_PIXELS=4; 1 blank clk between pixels and lines)
// - Single object: 3x3 block of 1s at x=5..7, y=2..4
//   -> box_done once; box=(5,7,2,4); cnt=9; valid=1.
// - Empty frame: all Bit=0 -> box=(0,0,0,0); cnt=0; valid=0; next frame post_box_flag stays 0.
// - Noise reject: only 2 object pixels at (0,0),(15,7) -> box=(0,15,0,7); cnt=2; valid=0.
// - Overlay: run frame 1 of the single-object case, then frame 2 all 0
//   -> in frame 2, post_box_flag=1 at exactly the 8 border pixels of (5..7,2..4); center (6,3)=0.
// - Reset mid-frame: assert rst_n=0 at line 3 of a frame with objects
//   -> all outputs 0; no box_done for that frame; the next full frame reports correctly.
// - Edge timing: a 1-pixel object on the last pixel of the last line, with vsync falling the
//   cycle after -> box=(15,15,7,7); box_done 2 clk after the vsync fall.

Source files
------------

// File: rtl/img_pkg.sv
// img_pkg: shared widths and FSM encoding for the binary-image stages
package img_pkg;
  localparam int IMG_XW = 11;
  localparam int IMG_CNTW = 20;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_LATCH = 2'd2} state_e;
endpackage

// File: rtl/bbox_accum.sv
// bbox_accum: running min/max of object-pixel coordinates plus saturating pixel count
module bbox_accum
  import img_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                sample_i,
  input  logic                bit_i,
  input  logic [IMG_XW-1:0]   x_i,
  input  logic [IMG_XW-1:0]   y_i,
  output logic [IMG_XW-1:0]   x_min_o,
  output logic [IMG_XW-1:0]   x_max_o,
  output logic [IMG_XW-1:0]   y_min_o,
  output logic [IMG_XW-1:0]   y_max_o,
  output logic [IMG_CNTW-1:0] cnt_o
);
  logic [IMG_XW-1:0] x_min_q, x_max_q, y_min_q, y_max_q;
  logic [IMG_CNTW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      x_min_q <= '1;
      x_max_q <= '0;
      y_min_q <= '1;
      y_max_q <= '0;
      cnt_q   <= '0;
    end else if (sample_i && bit_i) begin
      x_min_q <= (x_i < x_min_q) ? x_i : x_min_q;
      x_max_q <= (x_i > x_max_q) ? x_i : x_max_q;
      y_min_q <= (y_i < y_min_q) ? y_i : y_min_q;
      y_max_q <= (y_i > y_max_q) ? y_i : y_max_q;
      cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + IMG_CNTW'(1);
    end
  end
  assign x_min_o = x_min_q;
  assign x_max_o = x_max_q;
  assign y_min_o = y_min_q;
  assign y_max_o = y_max_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/bit_bbox_detector.sv
// bit_bbox_detector: per-frame bounding box / pixel count of a binary stream with box overlay
module bit_bbox_detector
  import img_pkg::*;
#(
  parameter logic [IMG_XW-1:0]   IMG_HDISP  = 11'd1024,
  parameter logic [IMG_XW-1:0]   IMG_VDISP  = 11'd768,
  parameter logic [IMG_CNTW-1:0] MIN_PIXELS = 20'd64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                per_frame_vsync,
  input  logic                per_frame_href,
  input  logic                per_frame_clken,
  input  logic                per_img_Bit,
  output logic                post_frame_vsync,
  output logic                post_frame_href,
  output logic                post_frame_clken,
  output logic                post_img_Bit,
  output logic                post_box_flag,
  output logic [IMG_XW-1:0]   box_x_min,
  output logic [IMG_XW-1:0]   box_x_max,
  output logic [IMG_XW-1:0]   box_y_min,
  output logic [IMG_XW-1:0]   box_y_max,
  output logic [IMG_CNTW-1:0] box_pix_cnt,
  output logic                box_valid,
  output logic                box_done
);
  localparam logic [IMG_XW-1:0] X_LAST = IMG_HDISP - IMG_XW'(1);
  localparam logic [IMG_XW-1:0] Y_LAST = IMG_VDISP - IMG_XW'(1);
  state_e state_q;
  logic vsync_q, href_q, rise_pend_q;
  logic vs_rise, vs_fall, href_fall, sample, clear, start;
  logic [IMG_XW-1:0] x_q, y_q, x_d, y_d;
  logic [IMG_XW-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [IMG_CNTW-1:0] acc_cnt;
  logic in_box, on_edge;
  assign vs_rise   = per_frame_vsync & ~vsync_q;
  assign vs_fall   = ~per_frame_vsync & vsync_q;
  assign href_fall = ~per_frame_href & href_q;
  assign sample    = (state_q == S_ACTIVE) & per_frame_href & per_frame_clken;
  assign start     = vs_rise | rise_pend_q;
  assign clear     = (state_q == S_IDLE) & start;
  always_comb begin
    x_d = href_fall ? '0 : sample ? ((x_q == X_LAST) ? x_q : x_q + IMG_XW'(1)) : x_q;
    y_d = href_fall ? ((y_q == Y_LAST) ? y_q : y_q + IMG_XW'(1)) : y_q;
  end
  bbox_accum u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (clear),
    .sample_i (sample),
    .bit_i    (per_img_Bit),
    .x_i      (x_q),
    .y_i      (y_q),
    .x_min_o  (acc_x_min),
    .x_max_o  (acc_x_max),
    .y_min_o  (acc_y_min),
    .y_max_o  (acc_y_max),
    .cnt_o    (acc_cnt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rise_pend_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      box_pix_cnt <= '0;
      box_valid   <= 1'b0;
      box_done    <= 1'b0;
    end else begin
      box_done    <= 1'b0;
      rise_pend_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          x_q     <= '0;
          y_q     <= '0;
          state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          x_q <= x_d;
          y_q <= y_d;
          if (vs_fall) state_q <= S_LATCH;
        end
        S_LATCH: begin
          box_x_min   <= (acc_cnt == '0) ? '0 : acc_x_min;
          box_x_max   <= (acc_cnt == '0) ? '0 : acc_x_max;
          box_y_min   <= (acc_cnt == '0) ? '0 : acc_y_min;
          box_y_max   <= (acc_cnt == '0) ? '0 : acc_y_max;
          box_pix_cnt <= acc_cnt;
          box_valid   <= acc_cnt >= MIN_PIXELS;
          box_done    <= 1'b1;
          rise_pend_q <= vs_rise;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign in_box  = (x_q >= box_x_min) && (x_q <= box_x_max) && (y_q >= box_y_min) && (y_q <= box_y_max);
  assign on_edge = (x_q == box_x_min) || (x_q == box_x_max) || (y_q == box_y_min) || (y_q == box_y_max);
  // vsync_q resets high so a frame already in progress at reset release is not seen as a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q          <= 1'b1;
      href_q           <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
      post_box_flag    <= 1'b0;
    end else begin
      vsync_q          <= per_frame_vsync;
      href_q           <= per_frame_href;
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_Bit     <= per_frame_href & per_img_Bit;
      post_box_flag    <= sample & box_valid & in_box & on_edge;
    end
  end
endmodule

// File: tb/tb_bit_bbox_detector.sv
// tb_bit_bbox_detector: directed frames with hand-computed boxes, overlay and timing checks
module tb_bit_bbox_detector;
  logic clk = 1'b0;
  logic rst_n, vsync, href, clken, bitv;
  logic post_vsync, post_href, post_clken, post_bit, post_flag;
  logic [10:0] bx0, bx1, by0, by1;
  logic [19:0] bcnt;
  logic bvalid, bdone;
  logic [15:0] img [8];
  logic fmap [8][16];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int pbit_sum = 0;
  int d0;
  always #5 clk = ~clk;
  always @(negedge clk) if (bdone) done_cnt++;
  bit_bbox_detector #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8), .MIN_PIXELS(20'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Bit(bitv),
    .post_frame_vsync(post_vsync), .post_frame_href(post_href), .post_frame_clken(post_clken),
    .post_img_Bit(post_bit), .post_box_flag(post_flag),
    .box_x_min(bx0), .box_x_max(bx1), .box_y_min(by0), .box_y_max(by1),
    .box_pix_cnt(bcnt), .box_valid(bvalid), .box_done(bdone)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_box(input string tag, input int x0, input int x1, input int y0, input int y1,
                         input int cnt, input logic valid);
    chk({tag, "_xmin"}, 32'(bx0), x0);
    chk({tag, "_xmax"}, 32'(bx1), x1);
    chk({tag, "_ymin"}, 32'(by0), y0);
    chk({tag, "_ymax"}, 32'(by1), y1);
    chk({tag, "_cnt"}, 32'(bcnt), cnt);
    chk({tag, "_valid"}, 32'(bvalid), 32'(valid));
  endtask
  task automatic clear_img;
    for (int y = 0; y < 8; y++) img[y] = '0;
  endtask
  task automatic send_line(input int y, input bit last);
    href = 1'b1;
    for (int x = 0; x < 16; x++) begin
      clken = 1'b1;
      bitv = img[y][x];
      tick;
      fmap[y][x] = post_flag;
      pbit_sum += int'(post_bit);
      if (y == 0 && x == 0) begin
        chk("lat_clken_hi", 32'(post_clken), 1);
        chk("lat_href_hi", 32'(post_href), 1);
      end
      if (!(last && x == 15)) begin
        clken = 1'b0;
        bitv = 1'b0;
        tick;
        if (y == 0 && x == 0) chk("lat_clken_lo", 32'(post_clken), 0);
      end
    end
    if (!last) begin
      href = 1'b0;
      tick;
    end
  endtask
  task automatic end_frame(input bit restart);
    vsync = 1'b0;
    href = 1'b0;
    clken = 1'b0;
    bitv = 1'b0;
    tick;
    chk("done_early", 32'(bdone), 0);
    if (restart) vsync = 1'b1;
    tick;
    chk("done_pulse", 32'(bdone), 1);
    tick;
    chk("done_width", 32'(bdone), 0);
  endtask
  task automatic run_frame(input bit tight, input bit restart);
    d0 = done_cnt;
    pbit_sum = 0;
    vsync = 1'b1;
    tick;
    chk("post_vsync", 32'(post_vsync), 1);
    tick;
    for (int y = 0; y < 8; y++) send_line(y, tight && y == 7);
    end_frame(restart);
    chk("done_once", 32'(done_cnt - d0), 1);
  endtask
  initial begin
    rst_n = 1'b0;
    vsync = 1'b1;
    href = 1'b1;
    clken = 1'b1;
    bitv = 1'b1;
    repeat (3) tick;
    chk("rst_post_vsync", 32'(post_vsync), 0);
    chk("rst_post_bit", 32'(post_bit), 0);
    chk("rst_done", 32'(bdone), 0);
    chk_box("rst", 0, 0, 0, 0, 0, 1'b0);
    href = 1'b0;
    clken = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("bit_gated_by_href", 32'(post_bit), 0);
    bitv = 1'b0;
    repeat (3) tick;
    vsync = 1'b0;
    repeat (4) tick;
    chk("no_rise_at_reset", 32'(done_cnt), 0);
    clear_img;
    for (int y = 2; y <= 4; y++) img[y][7:5] = 3'b111;
    run_frame(1'b0, 1'b0);
    chk_box("single", 5, 7, 2, 4, 9, 1'b1);
    chk("single_postbit", 32'(pbit_sum), 9);
    clear_img;
    run_frame(1'b0, 1'b0);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++)
        chk($sformatf("flag_%0d_%0d", x, y), 32'(fmap[y][x]),
            32'((x >= 5 && x <= 7 && y >= 2 && y <= 4) && (x == 5 || x == 7 || y == 2 || y == 4)));
    chk_box("empty", 0, 0, 0, 0, 0, 1'b0);
    run_frame(1'b0, 1'b0);
    begin
      int ones = 0;
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 16; x++) ones += int'(fmap[y][x]);
      chk("empty_no_flag", 32'(ones), 0);
    end
    clear_img;
    img[0][0] = 1'b1;
    img[7][15] = 1'b1;
    run_frame(1'b0, 1'b0);
    chk_box("noise", 0, 15, 0, 7, 2, 1'b0);
    clear_img;
    for (int y = 2; y <= 4; y++) img[y][7:5] = 3'b111;
    d0 = done_cnt;
    vsync = 1'b1;
    repeat (2) tick;
    for (int y = 0; y < 3; y++) send_line(y, 1'b0);
    href = 1'b1;
    for (int x = 0; x < 6; x++) begin
      clken = 1'b1;
      tick;
      clken = 1'b0;
      tick;
    end
    rst_n = 1'b0;
    #1;
    chk_box("midrst", 0, 0, 0, 0, 0, 1'b0);
    chk("midrst_post_href", 32'(post_href), 0);
    tick;
    rst_n = 1'b1;
    href = 1'b0;
    tick;
    for (int y = 4; y < 8; y++) send_line(y, 1'b0);
    vsync = 1'b0;
    repeat (5) tick;
    chk("midrst_no_done", 32'(done_cnt - d0), 0);
    run_frame(1'b0, 1'b0);
    chk_box("after_rst", 5, 7, 2, 4, 9, 1'b1);
    clear_img;
    img[7][15] = 1'b1;
    run_frame(1'b1, 1'b1);
    chk_box("edge", 15, 15, 7, 7, 1, 1'b0);
    clear_img;
    for (int y = 2; y <= 4; y++) img[y][7:5] = 3'b111;
    run_frame(1'b0, 1'b0);
    chk_box("latch_rise", 5, 7, 2, 4, 9, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
